// File: rtl/ddr3_read_checker.sv
// Read-data checker for the DDR3 exerciser: tracks issued READ addresses in a
// small tag FIFO, checks both returned beats against known patterns, and keeps counters/flags.
module ddr3_read_checker #(
    parameter logic [25:0] ADDRESS1 = 26'h0001400,
    parameter logic [25:0] ADDRESS2 = 26'h0001500,
    parameter logic [63:0] DATA1_1  = 64'h1AAA2AAA3AAA4AAA,
    parameter logic [63:0] DATA1_2  = 64'hE555D555C555B555,
    parameter logic [63:0] DATA2_1  = 64'h0123456789ABCDEF,
    parameter logic [63:0] DATA2_2  = 64'hFEDCBA9876543210,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic        cmd_rdy,
    input  logic [3:0]  cmd,
    input  logic [25:0] addr,
    input  logic [63:0] read_data,
    input  logic        read_data_valid,
    input  logic        wl_err,
    output logic [15:0] pass_cnt,
    output logic [15:0] fail_cnt,
    output logic        err_flag,
    output logic        timeout_flag,
    output logic        orphan_flag,
    output logic        overflow_flag,
    output logic [25:0] first_fail_addr,
    output logic        busy
);

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned PTR_W  = 2;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned ADDR_W = 26;
    localparam int unsigned CTR_W  = 16;
    localparam logic [3:0]  CMD_READ = 4'b0001;
    localparam logic [CTR_W-1:0] CTR_MAX = '1;

    typedef enum logic {S_WAIT, S_BEAT2} state_t;

    state_t                         state, state_next;
    logic [DEPTH-1:0][ADDR_W-1:0]   tag_mem;
    logic [PTR_W-1:0]               wr_ptr, rd_ptr;
    logic [CNT_W-1:0]               count, count_next;
    logic                           match0, match0_next;
    logic [CTR_W-1:0]               idle_cnt, idle_next;

    logic [ADDR_W-1:0] head_tag;
    logic              head_known;
    logic [63:0]       pat0, pat1;
    logic              push_req, push, pop, full, overflow_evt;
    logic              timeout_hit, burst_done, burst_pass, orphan_evt, fail_evt;

    // Head-of-FIFO tag decode into the expected beat patterns
    assign head_tag   = tag_mem[rd_ptr];
    assign head_known = (head_tag == ADDRESS1) || (head_tag == ADDRESS2);
    assign pat0       = (head_tag == ADDRESS1) ? DATA1_1 : DATA2_1;
    assign pat1       = (head_tag == ADDRESS1) ? DATA1_2 : DATA2_2;

    assign timeout_hit = busy && (idle_cnt == CTR_W'(TIMEOUT));

    // Burst state machine: next state and per-cycle events
    always_comb begin
        state_next  = state;
        match0_next = match0;
        pop         = 1'b0;
        burst_done  = 1'b0;
        burst_pass  = 1'b0;
        orphan_evt  = 1'b0;
        if (timeout_hit) begin
            pop        = 1'b1;
            state_next = S_WAIT;
        end else if (read_data_valid) begin
            case (state)
                S_WAIT: begin
                    if (count != '0) begin
                        match0_next = head_known && (read_data == pat0);
                        state_next  = S_BEAT2;
                    end else begin
                        orphan_evt = 1'b1;
                    end
                end
                S_BEAT2: begin
                    burst_done = 1'b1;
                    burst_pass = match0 && (read_data == pat1);
                    pop        = 1'b1;
                    state_next = S_WAIT;
                end
                default: state_next = S_WAIT;
            endcase
        end
    end

    // Tag FIFO occupancy; a pop on the same cycle frees room for a push into a full FIFO
    always_comb begin
        push_req     = cmd_valid && cmd_rdy && (cmd == CMD_READ);
        full         = (count == CNT_W'(DEPTH));
        push         = push_req && (!full || pop);
        overflow_evt = push_req && full && !pop;
        count_next   = count + CNT_W'(push) - CNT_W'(pop);
        fail_evt     = timeout_hit || (burst_done && !burst_pass);
        idle_next    = idle_cnt + CTR_W'(1);
        if (timeout_hit || read_data_valid || !busy) begin
            idle_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_WAIT;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_mem         <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            match0          <= 1'b0;
            idle_cnt        <= '0;
            pass_cnt        <= '0;
            fail_cnt        <= '0;
            err_flag        <= 1'b0;
            timeout_flag    <= 1'b0;
            orphan_flag     <= 1'b0;
            overflow_flag   <= 1'b0;
            first_fail_addr <= '0;
            busy            <= 1'b0;
        end else begin
            if (push) begin
                tag_mem[wr_ptr] <= addr;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count    <= count_next;
            busy     <= (count_next != '0);
            match0   <= match0_next;
            idle_cnt <= idle_next;
            if (burst_done && burst_pass && (pass_cnt != CTR_MAX)) begin
                pass_cnt <= pass_cnt + CTR_W'(1);
            end
            if (fail_evt && (fail_cnt != CTR_MAX)) begin
                fail_cnt <= fail_cnt + CTR_W'(1);
            end
            // fail_cnt only leaves zero through a fail, so it marks the first one
            if (fail_evt && (fail_cnt == '0)) begin
                first_fail_addr <= head_tag;
            end
            if (fail_evt || overflow_evt || orphan_evt || wl_err) begin
                err_flag <= 1'b1;
            end
            if (timeout_hit) begin
                timeout_flag <= 1'b1;
            end
            if (orphan_evt) begin
                orphan_flag <= 1'b1;
            end
            if (overflow_evt) begin
                overflow_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ddr3_read_checker.sv
// Randomized and directed bench for ddr3_read_checker against a queue-based
// transaction model of the read checking rules.
module tb_ddr3_read_checker;

    localparam int unsigned TMO = 16;
    localparam logic [3:0]  CMD_READ = 4'b0001;
    localparam logic [25:0] A1 = 26'h0001400;
    localparam logic [25:0] A2 = 26'h0001500;
    localparam logic [63:0] D11 = 64'h1AAA2AAA3AAA4AAA;
    localparam logic [63:0] D12 = 64'hE555D555C555B555;
    localparam logic [63:0] D21 = 64'h0123456789ABCDEF;
    localparam logic [63:0] D22 = 64'hFEDCBA9876543210;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_rdy = 1'b1;
    logic [3:0]  cmd = 4'b0000;
    logic [25:0] addr = '0;
    logic [63:0] read_data = '0;
    logic        read_data_valid = 1'b0;
    logic        wl_err = 1'b0;
    logic [15:0] pass_cnt, fail_cnt;
    logic        err_flag, timeout_flag, orphan_flag, overflow_flag, busy;
    logic [25:0] first_fail_addr;

    ddr3_read_checker #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_rdy(cmd_rdy), .cmd(cmd),
        .addr(addr), .read_data(read_data), .read_data_valid(read_data_valid),
        .wl_err(wl_err), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .err_flag(err_flag),
        .timeout_flag(timeout_flag), .orphan_flag(orphan_flag), .overflow_flag(overflow_flag),
        .first_fail_addr(first_fail_addr), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction-level model
    logic [25:0] mq[$];
    int          m_beat, m_idle;
    bit          m_ok0;
    logic [15:0] m_pass, m_fail;
    logic [25:0] m_ffa;
    bit          m_err, m_to, m_orph, m_ovf;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_known(input logic [25:0] a);
        return (a == A1) || (a == A2);
    endfunction

    function automatic logic [63:0] pattern(input logic [25:0] a, input int idx);
        if (a == A1) return (idx == 0) ? D11 : D12;
        if (a == A2) return (idx == 0) ? D21 : D22;
        return 64'h0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_beat = 0; m_idle = 0; m_ok0 = 0;
        m_pass = '0; m_fail = '0; m_ffa = '0;
        m_err = 0; m_to = 0; m_orph = 0; m_ovf = 0;
    endtask

    task automatic record_fail(input logic [25:0] tag);
        if (m_fail == 16'h0000) m_ffa = tag;
        if (m_fail != 16'hFFFF) m_fail = m_fail + 16'd1;
        m_err = 1;
    endtask

    task automatic model_step(input bit push_req, input logic [25:0] a, input bit dv,
                              input logic [63:0] d, input bit wl);
        bit          outstanding;
        logic [25:0] head;
        outstanding = (mq.size() != 0);
        head = outstanding ? mq[0] : 26'h0;
        if (outstanding && m_idle == int'(TMO)) begin
            m_to = 1;
            record_fail(head);
            void'(mq.pop_front());
            m_beat = 0;
            m_idle = 0;
        end else begin
            if (dv) begin
                if (!outstanding) begin
                    m_orph = 1;
                    m_err = 1;
                end else if (m_beat == 0) begin
                    m_ok0 = is_known(head) && (d == pattern(head, 0));
                    m_beat = 1;
                end else begin
                    if (m_ok0 && (d == pattern(head, 1))) begin
                        if (m_pass != 16'hFFFF) m_pass = m_pass + 16'd1;
                    end else begin
                        record_fail(head);
                    end
                    void'(mq.pop_front());
                    m_beat = 0;
                end
            end
            m_idle = (outstanding && !dv) ? m_idle + 1 : 0;
        end
        if (push_req) begin
            if (mq.size() < 4) mq.push_back(a);
            else begin
                m_ovf = 1;
                m_err = 1;
            end
        end
        if (wl) m_err = 1;
    endtask

    task automatic compare_all();
        check("pass_cnt", 64'(pass_cnt), 64'(m_pass));
        check("fail_cnt", 64'(fail_cnt), 64'(m_fail));
        check("flags", 64'({err_flag, timeout_flag, orphan_flag, overflow_flag}),
              64'({m_err, m_to, m_orph, m_ovf}));
        check("first_fail_addr", 64'(first_fail_addr), 64'(m_ffa));
        check("busy", 64'(busy), 64'(mq.size() != 0));
    endtask

    task automatic step(input bit v, input bit rdy, input logic [3:0] c, input logic [25:0] a,
                        input bit dv, input logic [63:0] d, input bit wl);
        cmd_valid = v; cmd_rdy = rdy; cmd = c; addr = a;
        read_data_valid = dv; read_data = d; wl_err = wl;
        model_step(v && rdy && (c == CMD_READ), a, dv, d, wl);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; read_data_valid = 1'b0; wl_err = 1'b0;
        compare_all();
    endtask

    task automatic issue_read(input logic [25:0] a);
        step(1, 1, CMD_READ, a, 0, 64'h0, 0);
    endtask

    task automatic send_beat(input logic [63:0] d);
        step(0, 1, 4'b0000, 26'h0, 1, d, 0);
    endtask

    task automatic idle_cycle();
        step(0, 1, 4'b0000, 26'h0, 0, 64'h0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pass"}, 64'(pass_cnt), 64'h0);
        check({tag, "_fail"}, 64'(fail_cnt), 64'h0);
        check({tag, "_flags"}, 64'({err_flag, timeout_flag, orphan_flag, overflow_flag}), 64'h0);
        check({tag, "_ffa"}, 64'(first_fail_addr), 64'h0);
        check({tag, "_busy"}, 64'(busy), 64'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        bit          v, rdy, dv, wl;
        logic [3:0]  c;
        logic [25:0] a;
        logic [63:0] d;

        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        check_all_zero("reset");

        // 1: clean read
        issue_read(A1);
        check("t1_busy_rise", 64'(busy), 64'h1);
        send_beat(D11);
        send_beat(D12);
        check("t1_pass", 64'(pass_cnt), 64'h1);
        check("t1_fail", 64'(fail_cnt), 64'h0);
        check("t1_err", 64'(err_flag), 64'h0);
        check("t1_busy_fall", 64'(busy), 64'h0);
        step(0, 1, 4'b0000, 26'h0, 0, 64'h0, 1);
        check("t1_wl_err", 64'(err_flag), 64'h1);

        // 2: data mismatch then good burst
        do_reset();
        issue_read(A2);
        send_beat(D21);
        send_beat(64'hFEDCBA9876543211);
        check("t2_fail", 64'(fail_cnt), 64'h1);
        check("t2_err", 64'(err_flag), 64'h1);
        check("t2_ffa", 64'(first_fail_addr), 64'(A2));
        issue_read(A1);
        send_beat(D11);
        send_beat(D12);
        check("t2_pass", 64'(pass_cnt), 64'h1);
        check("t2_ffa_hold", 64'(first_fail_addr), 64'(A2));

        // 3: overflow then back-to-back bursts
        do_reset();
        for (int i = 0; i < 5; i++) issue_read((i % 2 == 0) ? A1 : A2);
        check("t3_ovf", 64'(overflow_flag), 64'h1);
        for (int i = 0; i < 4; i++) begin
            send_beat(pattern((i % 2 == 0) ? A1 : A2, 0));
            send_beat(pattern((i % 2 == 0) ? A1 : A2, 1));
        end
        check("t3_pass", 64'(pass_cnt), 64'h4);
        check("t3_busy", 64'(busy), 64'h0);

        // 3b: push into a full FIFO on the pop cycle is accepted
        do_reset();
        for (int i = 0; i < 4; i++) issue_read(A1);
        send_beat(D11);
        step(1, 1, CMD_READ, A2, 1, D12, 0);
        check("t3b_no_ovf", 64'(overflow_flag), 64'h0);
        for (int i = 0; i < 3; i++) begin
            send_beat(D11);
            send_beat(D12);
        end
        send_beat(D21);
        send_beat(D22);
        check("t3b_pass", 64'(pass_cnt), 64'h5);

        // 4: orphan beat and unknown address
        do_reset();
        send_beat(D11);
        check("t4_orphan", 64'(orphan_flag), 64'h1);
        check("t4_cnt", 64'({pass_cnt, fail_cnt}), 64'h0);
        issue_read(26'h0000000);
        send_beat(64'h0);
        send_beat(64'h0);
        check("t4_unknown_fail", 64'(fail_cnt), 64'h1);

        // 5: timeout, then reset mid-burst
        do_reset();
        issue_read(A1);
        n = 0;
        while (!timeout_flag && n < 40) begin
            idle_cycle();
            n++;
        end
        check("t5_to_cycle", 64'(n), 64'd17);
        check("t5_to_flag", 64'(timeout_flag), 64'h1);
        check("t5_fail", 64'(fail_cnt), 64'h1);
        check("t5_busy", 64'(busy), 64'h0);
        issue_read(A1);
        send_beat(D11);
        cmd_valid = 1'b1; cmd = CMD_READ; addr = A2; read_data_valid = 1'b1; read_data = D12;
        do_reset();
        cmd_valid = 1'b0; read_data_valid = 1'b0;
        check_all_zero("t5_rst");
        issue_read(A2);
        send_beat(D21);
        send_beat(D22);
        check("t5_after_rst_pass", 64'(pass_cnt), 64'h1);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            n   = int'($urandom_range(0, 9));
            c   = (n < 7) ? CMD_READ : ((n < 9) ? 4'b0000 : 4'($urandom_range(0, 15)));
            n   = int'($urandom_range(0, 9));
            a   = (n < 4) ? A1 : ((n < 8) ? A2 : 26'($urandom));
            if (mq.size() != 0) dv = (m_idle >= 10) || ($urandom_range(0, 2) != 0);
            else dv = ($urandom_range(0, 19) == 0);
            d = {$urandom, $urandom};
            if (dv && mq.size() != 0 && $urandom_range(0, 9) != 0) d = pattern(mq[0], m_beat);
            wl = (i > 1200) && ($urandom_range(0, 99) == 0);
            step(v, rdy, c, a, dv, d, wl);
        end
        for (int i = 0; i < 12; i++) idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
